// File: rtl/cub_crbr_obuf_if.sv
// Crossbar output buffer bus: crossbar-side push, consumer-side pop,
// per-channel status, and the shared flush.
interface cub_crbr_obuf_if #(
    parameter int DWID   = 32,
    parameter int CH_OUT = 5,
    parameter int DEPTH  = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic                             flush;
    logic [CH_OUT-1:0][DWID-1:0]      cub_crbr_cflow_data_in;
    logic [CH_OUT-1:0]                cub_crbr_cflow_valid_in;
    logic [CH_OUT-1:0][DWID-1:0]      obuf_data_out;
    logic [CH_OUT-1:0]                obuf_valid_out;
    logic [CH_OUT-1:0]                obuf_ready_in;
    logic [CH_OUT-1:0][CW-1:0]        obuf_cnt;
    logic [CH_OUT-1:0]                obuf_full;
    logic [CH_OUT-1:0]                obuf_ovf_err;

    // Environment side: crossbar producer plus downstream consumer.
    modport master (
        output flush, cub_crbr_cflow_data_in, cub_crbr_cflow_valid_in, obuf_ready_in,
        input  obuf_data_out, obuf_valid_out, obuf_cnt, obuf_full, obuf_ovf_err
    );

    // Buffer side.
    modport slave (
        input  flush, cub_crbr_cflow_data_in, cub_crbr_cflow_valid_in, obuf_ready_in,
        output obuf_data_out, obuf_valid_out, obuf_cnt, obuf_full, obuf_ovf_err
    );
endinterface

// File: rtl/cub_crbr_obuf.sv
// Crossbar output buffer: one independent first-word fall-through FIFO per
// crossbar output channel. The crossbar cannot be stalled, so a push into a
// full channel (with no pop that cycle) is dropped and flagged sticky.

// Single channel FIFO.
module cub_crbr_obuf_ch #(
    parameter int DWID  = 32,
    parameter int DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          valid_in,
    input  logic [DWID-1:0]               data_in,
    input  logic                          ready_in,
    output logic                          valid_out,
    output logic [DWID-1:0]               data_out,
    output logic [$clog2(DEPTH+1)-1:0]    cnt,
    output logic                          full,
    output logic                          ovf_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DWID-1:0] mem [DEPTH];
    logic [AW-1:0]   wptr;
    logic [AW-1:0]   rptr;
    logic            pop;
    logic            push;
    logic            drop;

    // A pop frees a slot in the same cycle, so full+pop still accepts the push.
    always_comb begin
        full      = (cnt == CW'(DEPTH));
        valid_out = (cnt != '0);
        data_out  = valid_out ? mem[rptr] : '0;
        pop       = valid_out & ready_in & ~flush;
        push      = valid_in & ~flush & (~full | pop);
        drop      = valid_in & ~flush & full & ~pop;
    end

    // Storage is never cleared; only the pointers and count define content.
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= data_in;
    end

    // Pointers, count and sticky overflow; flush wins over push/pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr    <= '0;
            rptr    <= '0;
            cnt     <= '0;
            ovf_err <= 1'b0;
        end else if (flush) begin
            wptr    <= '0;
            rptr    <= '0;
            cnt     <= '0;
            ovf_err <= 1'b0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            if (push && !pop)      cnt <= cnt + 1'b1;
            else if (pop && !push) cnt <= cnt - 1'b1;
            if (drop) ovf_err <= 1'b1;
        end
    end
endmodule

// Top: array of channel FIFOs behind the bus interface.
module cub_crbr_obuf #(
    parameter int DWID   = 32,
    parameter int CH_OUT = 5,
    parameter int DEPTH  = 4
) (
    input  logic                clk,
    input  logic                rst,
    cub_crbr_obuf_if.slave      bus
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [CH_OUT-1:0][DWID-1:0] data_out;
    logic [CH_OUT-1:0]           valid_out;
    logic [CH_OUT-1:0][CW-1:0]   cnt;
    logic [CH_OUT-1:0]           full;
    logic [CH_OUT-1:0]           ovf_err;

    for (genvar c = 0; c < CH_OUT; c++) begin : g_ch
        cub_crbr_obuf_ch #(
            .DWID  (DWID),
            .DEPTH (DEPTH)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .flush     (bus.flush),
            .valid_in  (bus.cub_crbr_cflow_valid_in[c]),
            .data_in   (bus.cub_crbr_cflow_data_in[c]),
            .ready_in  (bus.obuf_ready_in[c]),
            .valid_out (valid_out[c]),
            .data_out  (data_out[c]),
            .cnt       (cnt[c]),
            .full      (full[c]),
            .ovf_err   (ovf_err[c])
        );
    end

    assign bus.obuf_data_out  = data_out;
    assign bus.obuf_valid_out = valid_out;
    assign bus.obuf_cnt       = cnt;
    assign bus.obuf_full      = full;
    assign bus.obuf_ovf_err   = ovf_err;
endmodule

// File: tb/tb_cub_crbr_obuf.sv
// Directed bench for cub_crbr_obuf: per-channel scoreboard queues filled as
// data is offered, popped and compared as the consumer accepts heads.
module tb_cub_crbr_obuf;
    localparam int DWID   = 32;
    localparam int CH_OUT = 5;
    localparam int DEPTH  = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cub_crbr_obuf_if #(.DWID(DWID), .CH_OUT(CH_OUT), .DEPTH(DEPTH)) bus ();

    cub_crbr_obuf #(.DWID(DWID), .CH_OUT(CH_OUT), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;
    logic [DWID-1:0] sbq [CH_OUT][$];
    int mcnt [CH_OUT];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        bus.flush                   = 1'b0;
        bus.cub_crbr_cflow_valid_in = '0;
        bus.cub_crbr_cflow_data_in  = '0;
        bus.obuf_ready_in           = '0;
    endtask

    // Offer one word; the model keeps it only if a slot is free.
    task automatic offer(input int c, input logic [DWID-1:0] d);
        bus.cub_crbr_cflow_valid_in[c] = 1'b1;
        bus.cub_crbr_cflow_data_in[c]  = d;
        if (mcnt[c] < DEPTH) begin
            sbq[c].push_back(d);
            mcnt[c]++;
        end
    endtask

    // Accept the current head and compare it against the scoreboard.
    task automatic consume(input int c);
        logic [DWID-1:0] e;
        e = sbq[c].pop_front();
        mcnt[c]--;
        chk($sformatf("head_valid_ch%0d", c), 64'(bus.obuf_valid_out[c]), 64'd1);
        chk($sformatf("head_data_ch%0d", c), 64'(bus.obuf_data_out[c]), 64'(e));
        bus.obuf_ready_in[c] = 1'b1;
    endtask

    task automatic drain(input int c);
        while (sbq[c].size() > 0) begin
            consume(c);
            tick;
            idle;
        end
        chk($sformatf("drained_cnt_ch%0d", c), 64'(bus.obuf_cnt[c]), 64'd0);
        chk($sformatf("drained_valid_ch%0d", c), 64'(bus.obuf_valid_out[c]), 64'd0);
    endtask

    task automatic model_clear;
        for (int c = 0; c < CH_OUT; c++) begin
            sbq[c].delete();
            mcnt[c] = 0;
        end
    endtask

    initial begin
        idle;
        model_clear;
        rst = 1'b1;
        #12;
        // Reset state
        for (int c = 0; c < CH_OUT; c++) begin
            chk($sformatf("rst_cnt_ch%0d", c), 64'(bus.obuf_cnt[c]), 64'd0);
            chk($sformatf("rst_data_ch%0d", c), 64'(bus.obuf_data_out[c]), 64'd0);
        end
        chk("rst_valid", 64'(bus.obuf_valid_out), 64'd0);
        chk("rst_full", 64'(bus.obuf_full), 64'd0);
        chk("rst_ovf", 64'(bus.obuf_ovf_err), 64'd0);
        rst = 1'b0;
        tick;

        // Single push on ch0, visible the next cycle, others untouched
        offer(0, 32'hA0);
        tick;
        idle;
        chk("ch0_valid", 64'(bus.obuf_valid_out[0]), 64'd1);
        chk("ch0_data", 64'(bus.obuf_data_out[0]), 64'hA0);
        chk("ch0_cnt", 64'(bus.obuf_cnt[0]), 64'd1);
        chk("others_empty", 64'(bus.obuf_valid_out[CH_OUT-1:1]), 64'd0);
        drain(0);

        // Overflow on ch2: fifth word dropped and flagged
        for (int i = 1; i <= 5; i++) begin
            offer(2, DWID'(i));
            tick;
        end
        idle;
        chk("ch2_cnt_full", 64'(bus.obuf_cnt[2]), 64'(DEPTH));
        chk("ch2_full", 64'(bus.obuf_full[2]), 64'd1);
        chk("ch2_ovf", 64'(bus.obuf_ovf_err[2]), 64'd1);
        chk("ovf_only_ch2", 64'(bus.obuf_ovf_err), 64'b00100);
        drain(2);
        chk("ch2_ovf_sticky", 64'(bus.obuf_ovf_err[2]), 64'd1);

        // Full ch1 with simultaneous pop accepts the push
        for (int i = 1; i <= 4; i++) begin
            offer(1, DWID'(i));
            tick;
        end
        idle;
        chk("ch1_full_pre", 64'(bus.obuf_full[1]), 64'd1);
        consume(1);
        offer(1, 32'h9);
        tick;
        idle;
        chk("ch1_cnt_kept", 64'(bus.obuf_cnt[1]), 64'(DEPTH));
        chk("ch1_no_ovf", 64'(bus.obuf_ovf_err[1]), 64'd0);
        drain(1);

        // Streaming through ch3: pointers wrap, count stays at one
        for (int k = 0; k < 10; k++) begin
            if (k > 0) begin
                consume(3);
                chk($sformatf("ch3_cnt_k%0d", k), 64'(bus.obuf_cnt[3]), 64'd1);
            end
            bus.obuf_ready_in[3] = 1'b1;
            offer(3, DWID'(k));
            tick;
            idle;
        end
        drain(3);

        // Flush with offered data clears everything, no ovf
        offer(4, 32'h41);
        tick;
        offer(4, 32'h42);
        tick;
        idle;
        for (int i = 0; i < 5; i++) begin
            offer(0, DWID'(32'h50 + i));
            tick;
        end
        idle;
        chk("ch0_ovf_pre_flush", 64'(bus.obuf_ovf_err[0]), 64'd1);
        chk("ch4_cnt_pre_flush", 64'(bus.obuf_cnt[4]), 64'd2);
        bus.flush                   = 1'b1;
        bus.cub_crbr_cflow_valid_in = '1;
        bus.cub_crbr_cflow_data_in  = {CH_OUT{32'hDEAD}};
        bus.obuf_ready_in           = '1;
        tick;
        idle;
        model_clear;
        for (int c = 0; c < CH_OUT; c++)
            chk($sformatf("flush_cnt_ch%0d", c), 64'(bus.obuf_cnt[c]), 64'd0);
        chk("flush_valid", 64'(bus.obuf_valid_out), 64'd0);
        chk("flush_ovf", 64'(bus.obuf_ovf_err), 64'd0);
        offer(0, 32'h55);
        tick;
        idle;
        drain(0);

        // Async reset mid-cycle with 3 entries buffered
        offer(2, 32'h11);
        tick;
        offer(2, 32'h22);
        tick;
        offer(2, 32'h33);
        tick;
        idle;
        chk("ch2_cnt_pre_rst", 64'(bus.obuf_cnt[2]), 64'd3);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 64'(bus.obuf_valid_out[2]), 64'd0);
        chk("async_rst_cnt", 64'(bus.obuf_cnt[2]), 64'd0);
        chk("async_rst_data", 64'(bus.obuf_data_out[2]), 64'd0);
        model_clear;
        tick;
        rst = 1'b0;
        offer(2, 32'h7);
        tick;
        idle;
        chk("post_rst_cnt", 64'(bus.obuf_cnt[2]), 64'd1);
        drain(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
